// File: rtl/key_schedule_iter_pkg.sv
// Shared definitions for the iterative AES key expansion: key-length encoding,
// per-mode word/round counts, FSM state type and the GF(2^8) xtime helper.
package key_schedule_iter_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  nk_of = NK_128;
      KL_192:  nk_of = NK_192;
      default: nk_of = NK_256;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  nr_of = NR_128;
      KL_192:  nr_of = NR_192;
      default: nr_of = NR_256;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_iter_subword.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bits [2047-8x -: 8], i.e. base offset 8*(255-x) = {~x,3'b0}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b000} +: 8];
  endfunction

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES key expansion: one 32-bit word per cycle, round keys emitted
// through a valid/ready output register that stalls generation when full.
module key_schedule_iter
  import key_schedule_iter_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  err,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [127:0]          rk_data,
  output logic [3:0]            rk_index,
  output logic                  rk_last
);

  localparam int IW = (MAX_NK > 1) ? $clog2(MAX_NK) : 1;

  state_e               state;
  logic [1:0]           klen;
  logic [32*MAX_NK-1:0] key_r;
  logic [31:0]          win [MAX_NK];
  logic [5:0]           i;
  logic [3:0]           j;
  logic [7:0]           rcon;

  logic [3:0]    nk, nr;
  logic [IW-1:0] old_sel;
  logic [31:0]   prev, sub_in, sub_out, temp, wn;
  logic          stall, adv, xfer, last_word;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Next-word datapath; j tracks i mod Nk so no divider is needed.
  always_comb begin
    nk      = nk_of(klen);
    nr      = nr_of(klen);
    old_sel = IW'(nk - 4'd1);
    prev    = win[0];
    sub_in  = (j == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
    if (j == 4'd0)
      temp = sub_out ^ {rcon, 24'h000000};
    else if (nk == NK_256 && j == 4'd4)
      temp = sub_out;
    else
      temp = prev;
    if (i < {2'b00, nk})
      wn = key_r[32*MAX_NK-1 -: 32];
    else
      wn = win[old_sel] ^ temp;
    xfer      = rk_valid && rk_ready;
    stall     = (i[1:0] == 2'd3) && rk_valid && !rk_ready;
    adv       = (state == GEN) && !stall;
    last_word = (i[1:0] == 2'd3) && (i[5:2] == nr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      klen     <= KL_128;
      key_r    <= '0;
      for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
      i        <= '0;
      j        <= '0;
      rcon     <= 8'h01;
      busy     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      rk_last  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (xfer) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (key_len == KL_BAD || int'(nk_of(key_len)) > MAX_NK) begin
              err <= 1'b1;
            end else begin
              klen  <= key_len;
              key_r <= key_in;
              for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
              i     <= '0;
              j     <= '0;
              rcon  <= 8'h01;
              busy  <= 1'b1;
              state <= GEN;
            end
          end
        end
        GEN: begin
          if (adv) begin
            win[0] <= wn;
            for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
            key_r <= key_r << 32;
            i     <= i + 6'd1;
            j     <= (j == nk - 4'd1) ? 4'd0 : j + 4'd1;
            if (i >= {2'b00, nk} && j == 4'd0) rcon <= xtime(rcon);
            if (i[1:0] == 2'd3) begin
              rk_data  <= {win[2], win[1], win[0], wn};
              rk_index <= i[5:2];
              rk_valid <= 1'b1;
              rk_last  <= last_word;
              if (last_word) state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (xfer) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed-vector bench for key_schedule_iter using FIPS-197 key expansions.
module tb_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  int total = 0;
  int bad   = 0;

  logic [127:0] got_data [16];
  logic [3:0]   got_idx  [16];
  logic         got_last [16];
  int           got_cyc  [16];
  int           ngot, unstable;
  bit           timed_out;
  logic         busy_after, valid_after;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] exp128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  key_schedule_iter #(.MAX_NK(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .busy     (busy),
    .err      (err),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .rk_last  (rk_last)
  );

  always #5 clk = ~clk;

  // Drive start for exactly one rising edge (the accept edge).
  task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    start   = 1'b1;
    key_len = kl;
    key_in  = k;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Records every transferred round key with the cycle it was seen after the accept edge.
  task automatic capture(input int max_cyc, input bit rand_ready, input int poke_cyc);
    bit stall_prev = 1'b0;
    bit done = 1'b0;
    logic [127:0] hold_d = '0;
    logic [3:0]   hold_i = '0;
    logic         hold_l = 1'b0;
    ngot = 0; unstable = 0; timed_out = 1'b1;
    busy_after = 1'bx; valid_after = 1'bx;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      start = (c == poke_cyc);
      if (c == poke_cyc) begin
        key_len = 2'd2;
        key_in  = {8{32'hc3c3a5a5}};
      end
      @(negedge clk);
      if (done) begin
        busy_after  = busy;
        valid_after = rk_valid;
        timed_out   = 1'b0;
        break;
      end
      if (stall_prev && (!rk_valid || rk_data !== hold_d || rk_index !== hold_i || rk_last !== hold_l))
        unstable++;
      rk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rk_valid && rk_ready) begin
        if (ngot < 16) begin
          got_data[ngot] = rk_data;
          got_idx[ngot]  = rk_index;
          got_last[ngot] = rk_last;
          got_cyc[ngot]  = c;
        end
        ngot++;
        if (rk_last) done = 1'b1;
      end
      stall_prev = rk_valid && !rk_ready;
      hold_d = rk_data; hold_i = rk_index; hold_l = rk_last;
    end
    start = 1'b0;
    rk_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total += 6;
    if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (err !== 1'b0)      begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
    if (rk_last !== 1'b0)  begin bad++; $display("FAIL reset_last: got %b want 0", rk_last); end
    if (rk_data !== '0)    begin bad++; $display("FAIL reset_data: got %h want 0", rk_data); end
    if (rk_index !== 4'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", rk_index); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aes128();
    rk_ready = 1'b1;
    do_start(2'd0, {K128, 128'h5555aaaa5555aaaa5555aaaa5555aaaa});
    capture(200, 1'b0, 0);
    total += 4;
    if (timed_out)     begin bad++; $display("FAIL a128_timeout: got 1 want 0"); end
    if (ngot !== 11)   begin bad++; $display("FAIL a128_count: got %0d want 11", ngot); end
    if (busy_after !== 1'b0)  begin bad++; $display("FAIL a128_busy_end: got %b want 0", busy_after); end
    if (valid_after !== 1'b0) begin bad++; $display("FAIL a128_valid_end: got %b want 0", valid_after); end
    for (int n = 0; n < 11 && n < ngot; n++) begin
      total += 4;
      if (got_data[n] !== exp128[n]) begin bad++; $display("FAIL a128_rk%0d: got %h want %h", n, got_data[n], exp128[n]); end
      if (got_idx[n] !== 4'(n))      begin bad++; $display("FAIL a128_idx%0d: got %0d want %0d", n, got_idx[n], n); end
      if (got_cyc[n] !== 4*(n+1))    begin bad++; $display("FAIL a128_cyc%0d: got %0d want %0d", n, got_cyc[n], 4*(n+1)); end
      if (got_last[n] !== (n == 10)) begin bad++; $display("FAIL a128_last%0d: got %b want %b", n, got_last[n], n == 10); end
    end
  endtask

  task automatic test_aes192();
    rk_ready = 1'b1;
    do_start(2'd1, {K192, 64'hffffffffffffffff});
    capture(200, 1'b0, 0);
    total += 2;
    if (timed_out)   begin bad++; $display("FAIL a192_timeout: got 1 want 0"); end
    if (ngot !== 13) begin bad++; $display("FAIL a192_count: got %0d want 13", ngot); end
    if (ngot == 13) begin
      total += 6;
      if (got_data[0] !== 128'h000102030405060708090a0b0c0d0e0f)
        begin bad++; $display("FAIL a192_rk0: got %h want 000102030405060708090a0b0c0d0e0f", got_data[0]); end
      if (got_data[1][127:64] !== 64'h1011121314151617)
        begin bad++; $display("FAIL a192_rk1_hi: got %h want 1011121314151617", got_data[1][127:64]); end
      if (got_data[12] !== 128'ha4970a331a78dc09c418c271e3a41d5d)
        begin bad++; $display("FAIL a192_rk12: got %h want a4970a331a78dc09c418c271e3a41d5d", got_data[12]); end
      if (got_idx[12] !== 4'd12) begin bad++; $display("FAIL a192_idx12: got %0d want 12", got_idx[12]); end
      if (got_last[12] !== 1'b1 || got_last[11] !== 1'b0)
        begin bad++; $display("FAIL a192_last: got %b%b want 01", got_last[11], got_last[12]); end
      if (got_cyc[12] !== 52) begin bad++; $display("FAIL a192_cyc12: got %0d want 52", got_cyc[12]); end
    end
  endtask

  task automatic check_aes256(input string tag);
    total += 2;
    if (timed_out)   begin bad++; $display("FAIL %s_timeout: got 1 want 0", tag); end
    if (ngot !== 15) begin bad++; $display("FAIL %s_count: got %0d want 15", tag, ngot); end
    if (ngot == 15) begin
      total += 6;
      if (got_data[0] !== K256[255:128]) begin bad++; $display("FAIL %s_rk0: got %h want %h", tag, got_data[0], K256[255:128]); end
      if (got_data[1] !== K256[127:0])   begin bad++; $display("FAIL %s_rk1: got %h want %h", tag, got_data[1], K256[127:0]); end
      if (got_data[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36)
        begin bad++; $display("FAIL %s_rk14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", tag, got_data[14]); end
      if (got_idx[14] !== 4'd14) begin bad++; $display("FAIL %s_idx14: got %0d want 14", tag, got_idx[14]); end
      if (got_last[14] !== 1'b1 || got_last[13] !== 1'b0)
        begin bad++; $display("FAIL %s_last: got %b%b want 01", tag, got_last[13], got_last[14]); end
      if (got_cyc[14] !== 60) begin bad++; $display("FAIL %s_cyc14: got %0d want 60", tag, got_cyc[14]); end
    end
  endtask

  task automatic test_aes256();
    rk_ready = 1'b1;
    do_start(2'd2, K256);
    capture(200, 1'b0, 0);
    check_aes256("a256");
  endtask

  task automatic test_backpressure();
    do_start(2'd0, {K128, 128'h0123456789abcdef0123456789abcdef});
    capture(600, 1'b1, 0);
    total += 3;
    if (timed_out)       begin bad++; $display("FAIL bp_timeout: got 1 want 0"); end
    if (ngot !== 11)     begin bad++; $display("FAIL bp_count: got %0d want 11", ngot); end
    if (unstable !== 0)  begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    for (int n = 0; n < 11 && n < ngot; n++) begin
      total += 2;
      if (got_data[n] !== exp128[n]) begin bad++; $display("FAIL bp_rk%0d: got %h want %h", n, got_data[n], exp128[n]); end
      if (got_idx[n] !== 4'(n))      begin bad++; $display("FAIL bp_idx%0d: got %0d want %0d", n, got_idx[n], n); end
    end
  endtask

  task automatic test_illegal();
    do_start(2'd3, K256);
    @(negedge clk);
    total += 3;
    if (err !== 1'b1)      begin bad++; $display("FAIL illegal_err: got %b want 1", err); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL illegal_busy: got %b want 0", busy); end
    if (rk_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid: got %b want 0", rk_valid); end
    @(negedge clk);
    total += 2;
    if (err !== 1'b0)  begin bad++; $display("FAIL illegal_err_pulse: got %b want 0", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy2: got %b want 0", busy); end
  endtask

  task automatic test_start_during_gen();
    rk_ready = 1'b1;
    do_start(2'd0, {K128, 128'h0});
    capture(200, 1'b0, 9);
    total += 3;
    if (ngot !== 11) begin bad++; $display("FAIL ignore_count: got %0d want 11", ngot); end
    if (ngot == 11 && got_data[10] !== exp128[10])
      begin bad++; $display("FAIL ignore_rk10: got %h want %h", got_data[10], exp128[10]); end
    if (ngot == 11 && got_data[3] !== exp128[3])
      begin bad++; $display("FAIL ignore_rk3: got %h want %h", got_data[3], exp128[3]); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    rk_ready = 1'b1;
    do_start(2'd0, {K128, 128'h0});
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rk_valid && rk_index == 4'd5) begin seen = 1'b1; break; end
    end
    total += 1;
    if (!seen) begin bad++; $display("FAIL mid_reach_r5: got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (rk_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", rk_valid); end
    if (rk_data !== '0)    begin bad++; $display("FAIL mid_data: got %h want 0", rk_data); end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(2'd2, K256);
    capture(200, 1'b0, 0);
    check_aes256("mid256");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key_in = '0; rk_ready = 1'b1;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_illegal();
    test_start_during_gen();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_schedule_iter.md
KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Parameter MAX_NK, default 8, SHALL set the window depth in 32-bit words and the key_in width (32*MAX_NK); legal values are 4, 6 and 8.
REQ-003 Ports (name, direction, width, meaning):
  clk       in   1           clock
  rst_n     in   1           async active-low reset
  start     in   1           begin expansion; sampled in IDLE only
  key_len   in   2           0=AES-128 (Nk4,Nr10), 1=AES-192 (Nk6,Nr12), 2=AES-256 (Nk8,Nr14), 3=illegal
  key_in    in   32*MAX_NK   cipher key, MSB-aligned; w0 = key_in[top:top-31]
  busy      out  1           expansion in progress
  err       out  1           one-cycle pulse on illegal start
  rk_valid  out  1           round key available
  rk_ready  in   1           consumer accepts round key
  rk_data   out  128         round key, w[4r] in [127:96]
  rk_index  out  4           round number r
  rk_last   out  1           rk_data is round Nr

Function
REQ-004 The FSM SHALL have states IDLE, GEN and FLUSH.
REQ-005 In IDLE, start=1 with legal key_len SHALL latch key_in and key_len, clear word counter i, and enter GEN next cycle; busy rises the same edge.
REQ-006 In IDLE, start=1 with key_len=3 (or Nk>MAX_NK) SHALL pulse err for one cycle and remain IDLE.
REQ-007 start outside IDLE SHALL be ignored.
REQ-008 In GEN, one word w[i] SHALL be produced per unstalled cycle: i<Nk copies key word i; else w[i]=w[i-Nk]^temp.
REQ-009 temp SHALL be SubWord(RotWord(w[i-1]))^Rcon[i/Nk] when i mod Nk=0; SubWord(w[i-1]) when Nk=8 and i mod 8=4; else w[i-1].
REQ-010 Rcon SHALL start at 0x01 and advance by GF(2^8) xtime (poly 0x11b) after each use; only the top byte is non-zero.
REQ-011 Words SHALL enter a sliding window of MAX_NK words; w[i-Nk] is selected by latched key_len.
REQ-012 Every fourth word SHALL complete a 128-bit round key, moved to the output register with rk_valid=1, rk_index=i/4.
REQ-013 Output transfer SHALL occur on rk_valid & rk_ready; rk_data/rk_index/rk_last SHALL be stable while rk_valid=1 and rk_ready=0.
REQ-014 If a round key completes while the output register is full and not transferring that cycle, generation SHALL stall with no word lost or duplicated.
REQ-015 With rk_ready held high, round key r SHALL be valid exactly 4(r+1) cycles after the start-accept edge; throughput one round key per 4 cycles.
REQ-016 After word 4Nr+3 the FSM SHALL enter FLUSH; on transfer of rk_last=1 it SHALL return to IDLE and deassert busy the same edge.
REQ-017 rk_last SHALL be 1 only with rk_index=Nr.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE and busy=0, err=0, rk_valid=0, rk_last=0, rk_data=0, rk_index=0, i=0, Rcon=0x01, window=0.
REQ-019 Reset mid-expansion SHALL discard all state; the first post-reset start SHALL produce a full correct schedule.

Structure
REQ-020 A shared package SHALL hold the key_len encoding, Nk/Nr per mode, the FSM state type, and the xtime function.
REQ-021 One sub-module, aes_subword (four S-box instances, 32-bit in/out), SHALL be instantiated once; no other S-box logic.

Verification
REQ-022 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 keys; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 44, rk_last=1.
REQ-023 AES-192, key 000102...1617 -> 13 keys; round 12 = a4970a331a78dc09c418c271e3a41d5d.
REQ-024 AES-256, key 000102...1e1f -> 15 keys; round 14 = 24fc79ccbf0979e9371ac23c6d68de36.
REQ-025 AES-128 with random rk_ready backpressure -> same 11 keys in order, none duplicated, outputs stable while stalled.
REQ-026 start with key_len=3 -> err one cycle, busy=0; start pulsed during GEN -> ignored; rst_n low at round 5 then new AES-256 start -> correct full schedule.
